// File: rtl/wb_pkg.sv
// Shared Wishbone slave types: bus widths, slave FSM states and the byte-lane merge helper.
package wb_pkg;
  localparam int WB_DW   = 32;
  localparam int WB_AW   = 32;
  localparam int WB_SELW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} wb_slv_state_t;

  // Replace each byte of old_word whose sel bit is set with the matching byte of new_word.
  function automatic logic [WB_DW-1:0] wb_byte_merge(
    input logic [WB_DW-1:0]   old_word,
    input logic [WB_DW-1:0]   new_word,
    input logic [WB_SELW-1:0] sel
  );
    logic [WB_DW-1:0] r;
    r = old_word;
    for (int i = 0; i < WB_SELW; i++)
      if (sel[i]) r[8*i +: 8] = new_word[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/wb_sram_bank.sv
// Single-port DEPTH x 32 RAM with byte-enable write and synchronous read.
// rdata holds the word only in the cycle after a read strobe and is zero otherwise.
module wb_sram_bank
  import wb_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               we,
  input  logic [WB_SELW-1:0] sel,
  input  logic [IW-1:0]      idx,
  input  logic [WB_DW-1:0]   wdata,
  output logic [WB_DW-1:0]   rdata
);
  logic [WB_DW-1:0] mem [DEPTH];

  // Contents are deliberately left out of reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (en && we) mem[idx] <= wb_byte_merge(mem[idx], wdata, sel);
    if (rst) rdata <= '0;
    else     rdata <= (en && !we) ? mem[idx] : '0;
  end
endmodule

// File: rtl/wishbone_slave_ram.sv
// Wishbone B4 classic single-transfer RAM slave with WAIT_CYCLES wait states.
// Define WB_SLAVE_ERR_EN to answer out-of-window or misaligned requests with err.
module wishbone_slave_ram
  import wb_pkg::*;
#(
  parameter int               DEPTH       = 256,
  parameter logic [WB_AW-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int               WAIT_CYCLES = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [WB_AW-1:0]   i_wishbone_addr,
  input  logic [WB_DW-1:0]   i_wishbone_data,
  input  logic               i_wishbone_we,
  input  logic [WB_SELW-1:0] i_wishbone_sel,
  input  logic               i_wishbone_stb,
  input  logic               i_wishbone_cyc,
  output logic [WB_DW-1:0]   o_wishbone_data,
  output logic               o_wishbone_ack,
  output logic               o_wishbone_err
);
  localparam int IW = $clog2(DEPTH);

  wb_slv_state_t state;
  logic [3:0]    cnt;
  logic          req, go_ack, bad, ack, err;

  assign req = i_wishbone_cyc & i_wishbone_stb;

  // High exactly at the edge that enters S_ACK; bus fields are sampled there.
  always_comb begin
    go_ack = 1'b0;
    if (state == S_IDLE && req && WAIT_CYCLES == 0) go_ack = 1'b1;
    if (state == S_WAIT && req && cnt == 4'd1)      go_ack = 1'b1;
  end

`ifdef WB_SLAVE_ERR_EN
  assign bad = (i_wishbone_addr[WB_AW-1:IW+2] != BASE_ADDR[WB_AW-1:IW+2]) ||
               (i_wishbone_addr[1:0] != 2'b00);
`else
  // Upper address bits alias and the byte offset is ignored.
  logic unused_addr;
  assign bad = 1'b0;
  assign unused_addr = ^{i_wishbone_addr[WB_AW-1:IW+2], i_wishbone_addr[1:0], BASE_ADDR};
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
    end else begin
      ack <= go_ack & ~bad;
      err <= go_ack & bad;
      case (state)
        S_IDLE: if (req) begin
          if (WAIT_CYCLES == 0) state <= S_ACK;
          else begin
            state <= S_WAIT;
            cnt   <= 4'(WAIT_CYCLES);
          end
        end
        S_WAIT: begin
          if (!req) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == 4'd1) begin
            state <= S_ACK;
            cnt   <= '0;
          end else cnt <= cnt - 4'd1;
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  wb_sram_bank #(.DEPTH(DEPTH)) u_bank (
    .clk   (i_clk),
    .rst   (i_rst),
    .en    (go_ack & ~bad & ~i_rst),
    .we    (i_wishbone_we),
    .sel   (i_wishbone_sel),
    .idx   (i_wishbone_addr[IW+1:2]),
    .wdata (i_wishbone_data),
    .rdata (o_wishbone_data)
  );

  assign o_wishbone_ack = ack;
  assign o_wishbone_err = err;
endmodule

// File: doc/wishbone_slave_ram.md
Name: wishbone_slave_ram

Overview:
Wishbone B4 classic single-transfer slave. Word-organised RAM with byte-lane writes and a parameterised number of wait states. It is the responder end of the CPU-side wishbone bus interface, and it serves as the instruction and data memory behind that master in SoC and system simulation.

Parameters:
DEPTH, 256, number of 32-bit words; power of two.
BASE_ADDR, 32'h0000_0000, byte base address of the window; aligned to DEPTH*4.
WAIT_CYCLES, 1, wait states inserted before ack; range 0..15.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  synchronous, active-high reset.
i_wishbone_addr  input  32  byte address.
i_wishbone_data  input  32  write data.
i_wishbone_we  input  1  1 = write, 0 = read.
i_wishbone_sel  input  4  byte-lane select; bit i maps to data[8i+7:8i].
i_wishbone_stb  input  1  strobe.
i_wishbone_cyc  input  1  bus cycle valid.
o_wishbone_data  output  32  read data; valid only while ack is high.
o_wishbone_ack  output  1  one-cycle transfer acknowledge.
o_wishbone_err  output  1  error acknowledge; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset: state S_IDLE, wait counter 0, o_wishbone_ack = 0, o_wishbone_err = 0, o_wishbone_data = 0.
- Reset does not clear memory contents. Reset during S_WAIT or S_ACK aborts the transfer, with no write and no ack.
- Request: cyc & stb sampled high at an edge while in S_IDLE.
- Word index = addr[log2(DEPTH)+1:2].
- FSM (all outputs registered):
  - S_IDLE: on a request:
    - WAIT_CYCLES = 0: go to S_ACK.
    - Otherwise: go to S_WAIT and load cnt = WAIT_CYCLES.
  - S_WAIT:
    - If cyc or stb is low: abort to S_IDLE, no write, no ack.
    - Else if cnt == 1: go to S_ACK.
    - Else: cnt decrements.
  - S_ACK: ack high for exactly one cycle, then unconditionally go to S_IDLE.
- Address, data, we and sel are sampled at the edge that enters S_ACK (the master holds them stable until ack).
- Latency: stb visible -> ack visible = WAIT_CYCLES+1 cycles.
- Back-to-back: if the master keeps cyc & stb high after ack, S_IDLE treats it as a new request at the next edge. Ack is never high in two consecutive cycles.
- Write: performed at the edge entering S_ACK; each lane with sel[i]=1 is written. sel = 0 is acked with no change.
- Read: full 32-bit word, sel ignored. o_wishbone_data is registered at the edge entering S_ACK and forced to 0 in every cycle where ack is low.
- Read-after-write to the same word in the next transfer returns the new data.
- Default build (no error response):
  - Address bits above the index alias; addr[1:0] is ignored.
  - Every request is acked.

Optional Feature:
WB_SLAVE_ERR_EN
- Defined:
  - A request with addr outside [BASE_ADDR, BASE_ADDR+DEPTH*4), or with addr[1:0] != 0, completes with o_wishbone_err high for one cycle in place of ack.
  - Same latency as ack; no write; o_wishbone_data = 0.
  - err and ack are never high together.
- Undefined: o_wishbone_err is constant 0 and the aliasing rules above apply.

Decomposition:
- Package wb_pkg:
  - WB_DW = 32, WB_AW = 32, WB_SELW = 4.
  - typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} wb_slv_state_t.
  - Function wb_byte_merge(old, new, sel).
- Sub-module wb_sram_bank: single-port DEPTH x 32 array with byte-enable write and synchronous read. The top module holds the FSM, wait counter, address decode and error logic.

Test Plan:
1. WAIT_CYCLES=2. Write addr 0x10, data 0xDEADBEEF, sel 0xF -> ack high exactly 3 cycles after stb, 1 cycle wide. Read 0x10 -> o_wishbone_data = 0xDEADBEEF in the ack cycle and 0 otherwise.
2. Write addr 0x10, sel 0x2, data 0x0000AA00 -> read 0x10 returns 0xDEADAAEF. Write with sel 0x0 -> acked, read unchanged.
3. cyc/stb dropped one cycle into S_WAIT of a write of 0x12345678 to 0x10 -> no ack in the next 10 cycles; read 0x10 still returns 0xDEADAAEF.
4. Master holds stb high after ack and issues a new read of 0x14 (WAIT_CYCLES=0) -> acks spaced exactly 2 cycles apart, never consecutive.
5. i_rst pulsed while in S_WAIT -> ack and err are 0 on the following cycle, FSM in S_IDLE; a subsequent read of 0x10 returns 0xDEADAAEF.
6. DEPTH=256, BASE_ADDR=0, read 0x400:
   - With WB_SLAVE_ERR_EN: err pulse, ack 0, data 0. Addr 0x13 -> err.
   - Without: 0x400 aliases to 0x0 and is acked; 0x13 returns word 0x10.
